// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz trajectory engine: FSM states and result codes.
package collatz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ZERO    = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/collatz_if.sv
// Control/result bundle between a requester and the Collatz engine.
interface collatz_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 10
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] seed;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] value;
  logic [CNT_W-1:0] steps;
  logic [WIDTH-1:0] peak;
  logic [1:0]       err;

  modport master (
    output start, abort, seed,
    input  busy, done, value, steps, peak, err
  );

  modport slave (
    input  start, abort, seed,
    output busy, done, value, steps, peak, err
  );
endinterface

// File: rtl/collatz_step.sv
// One combinational Collatz step; the odd branch is formed at WIDTH+2 bits to expose overflow.
module collatz_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] next,
  output logic             ovf
);
  logic [WIDTH+1:0] wide;
  logic [WIDTH+1:0] tri_v;

  always_comb begin
    wide  = {2'b00, cur};
    tri_v = (wide << 1) + wide + (WIDTH+2)'(1);
    if (cur[0]) begin
      next = tri_v[WIDTH-1:0];
      ovf  = |tri_v[WIDTH+1:WIDTH];
    end else begin
      next = {1'b0, cur[WIDTH-1:1]};
      ovf  = 1'b0;
    end
  end
endmodule

// File: rtl/collatz_top.sv
// Project wrapper: an 8-bit Collatz engine brought out to discrete pins.
module collatz_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] seed,
  output logic       busy,
  output logic       done,
  output logic [7:0] value,
  output logic [9:0] steps,
  output logic [7:0] peak,
  output logic [1:0] err
);
  collatz_if #(.WIDTH(8), .CNT_W(10)) u_if ();

  collatz_engine #(.WIDTH(8), .CNT_W(10)) u_eng (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  assign u_if.start = start;
  assign u_if.abort = abort;
  assign u_if.seed  = seed;
  assign busy  = u_if.busy;
  assign done  = u_if.done;
  assign value = u_if.value;
  assign steps = u_if.steps;
  assign peak  = u_if.peak;
  assign err   = u_if.err;
endmodule

// File: rtl/collatz_engine.sv
// Iterates the Collatz map from a seed, tracking step count and peak, with overflow/timeout guards.
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  collatz_if.slave bus
);
  localparam logic [CNT_W-1:0] STEPS_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [1:0]       err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_nxt;
  logic             step_ovf;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .cur  (value_q),
    .next (step_nxt),
    .ovf  (step_ovf)
  );

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    peak_d  = peak_q;
    steps_d = steps_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          steps_d = '0;
          if (bus.seed == '0) begin
            value_d = '0;
            peak_d  = '0;
            err_d   = ERR_ZERO;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            value_d = bus.seed;
            peak_d  = bus.seed;
            err_d   = ERR_OK;
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Guards are checked before the step so a rejected step leaves results untouched.
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (value_q == WIDTH'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else if (steps_q == STEPS_MAX) begin
          err_d   = ERR_TIMEOUT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else if (step_ovf) begin
          err_d   = ERR_OVF;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          value_d = step_nxt;
          steps_d = steps_q + CNT_W'(1);
          peak_d  = (step_nxt > peak_q) ? step_nxt : peak_q;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      peak_q  <= '0;
      steps_q <= '0;
      err_q   <= ERR_OK;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      peak_q  <= peak_d;
      steps_q <= steps_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.value = value_q;
  assign bus.steps = steps_q;
  assign bus.peak  = peak_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_collatz_engine.sv
// Bench for collatz_engine: three configurations share one stimulus stream, results are scoreboarded.
module tb_collatz_engine;
  typedef struct {
    logic [31:0] value;
    logic [31:0] steps;
    logic [31:0] peak;
    logic [31:0] err;
    logic [31:0] tdone;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] seed = '0;
  logic [31:0] cyc = '0;
  int          nvec = 0;
  int          nmis = 0;
  exp_t        q16[$];
  exp_t        q8[$];
  exp_t        qt[$];
  exp_t        e16, e8, et;

  logic       b8, d8;
  logic [7:0] v8, p8;
  logic [9:0] s8;
  logic [1:0] r8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  collatz_if #(.WIDTH(16), .CNT_W(10)) i16 ();
  collatz_if #(.WIDTH(16), .CNT_W(4))  itm ();

  assign i16.start = start;
  assign i16.abort = abort;
  assign i16.seed  = seed;
  assign itm.start = start;
  assign itm.abort = abort;
  assign itm.seed  = seed;

  collatz_engine #(.WIDTH(16), .CNT_W(10)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
  collatz_engine #(.WIDTH(16), .CNT_W(4))  utm (.clk(clk), .rst_n(rst_n), .bus(itm.slave));
  collatz_top u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed[7:0]),
    .busy(b8), .done(d8), .value(v8), .steps(s8), .peak(p8), .err(r8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] sd, input int w, input int cw,
                                 input logic [31:0] t0);
    exp_t   r;
    longint v, p, n;
    int     s;
    v = longint'(sd);
    p = v;
    s = 0;
    if (sd == 0) begin
      r.value = 0; r.steps = 0; r.peak = 0; r.err = 1; r.tdone = t0;
      return r;
    end
    while (1) begin
      if (v == 1) begin r.err = 0; break; end
      if (s == (1 << cw) - 1) begin r.err = 3; break; end
      if (v % 2 == 1) begin
        n = 3 * v + 1;
        if (n >= (longint'(1) << w)) begin r.err = 2; break; end
      end else begin
        n = v / 2;
      end
      v = n;
      s++;
      if (v > p) p = v;
    end
    r.value = 32'(v);
    r.steps = 32'(s);
    r.peak  = 32'(p);
    r.tdone = t0 + 32'(s) + 1;
    return r;
  endfunction

  task automatic cmp(input string tg, input exp_t e, input logic [31:0] v, input logic [31:0] s,
                     input logic [31:0] p, input logic [31:0] er);
    chk({tg, "_lat"}, cyc, e.tdone);
    chk({tg, "_val"}, v, e.value);
    chk({tg, "_stp"}, s, e.steps);
    chk({tg, "_pk"},  p, e.peak);
    chk({tg, "_err"}, er, e.err);
  endtask

  always @(negedge clk) if (rst_n && i16.done) begin
    if (q16.size() == 0) chk("spur16", 1, 0);
    else begin
      e16 = q16.pop_front();
      cmp("u16", e16, 32'(i16.value), 32'(i16.steps), 32'(i16.peak), 32'(i16.err));
    end
  end

  always @(negedge clk) if (rst_n && d8) begin
    if (q8.size() == 0) chk("spur8", 1, 0);
    else begin
      e8 = q8.pop_front();
      cmp("u8", e8, 32'(v8), 32'(s8), 32'(p8), 32'(r8));
    end
  end

  always @(negedge clk) if (rst_n && itm.done) begin
    if (qt.size() == 0) chk("spurT", 1, 0);
    else begin
      et = qt.pop_front();
      cmp("uT", et, 32'(itm.value), 32'(itm.steps), 32'(itm.peak), 32'(itm.err));
    end
  end

  task automatic go(input logic [15:0] s);
    logic [31:0] t0;
    int n;
    @(posedge clk); #1;
    start = 1'b1;
    seed  = s;
    t0    = cyc + 1;
    q16.push_back(model(32'(s), 16, 10, t0));
    q8.push_back(model(32'(s[7:0]), 8, 10, t0));
    qt.push_back(model(32'(s), 16, 4, t0));
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy16", 32'(i16.busy), 32'(s != 0));
    chk("busy8", 32'(b8), 32'(s[7:0] != 0));
    n = 0;
    while ((q16.size() + q8.size() + qt.size()) != 0 && n < 1100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1100) begin
      chk("done_wait", 1, 0);
      q16.delete(); q8.delete(); qt.delete();
    end
  endtask

  task automatic chk_zero16(input string tg);
    chk({tg, "_busy"}, 32'(i16.busy), 0);
    chk({tg, "_done"}, 32'(i16.done), 0);
    chk({tg, "_val"},  32'(i16.value), 0);
    chk({tg, "_stp"},  32'(i16.steps), 0);
    chk({tg, "_pk"},   32'(i16.peak), 0);
    chk({tg, "_err"},  32'(i16.err), 0);
    chk({tg, "_val8"}, 32'(v8), 0);
    chk({tg, "_stpT"}, 32'(itm.steps), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero16("rst");
    rst_n = 1'b1;

    go(16'd6);
    chk("s6_val", 32'(i16.value), 1);
    chk("s6_stp", 32'(i16.steps), 8);
    chk("s6_pk",  32'(i16.peak), 16);
    chk("s6_err", 32'(i16.err), 0);
    go(16'd1);
    chk("s1_stp", 32'(i16.steps), 0);
    go(16'd0);
    chk("s0_err", 32'(i16.err), 1);
    go(16'd27);
    chk("s27_err8", 32'(r8), 2);
    chk("s27_val8", 32'(v8), 107);
    chk("s27_stp8", 32'(s8), 11);
    chk("s27_pk8",  32'(p8), 214);
    go(16'd7);
    chk("s7_errT", 32'(itm.err), 3);
    chk("s7_stpT", 32'(itm.steps), 15);
    chk("s7_valT", 32'(itm.value), 2);
    chk("s7_pkT",  32'(itm.peak), 52);
    for (int i = 0; i < 6; i++) go(16'($urandom_range(2, 3000)));

    // Abort after five steps, with a stray start during RUN and start raised alongside abort.
    @(posedge clk); #1;
    start = 1'b1; seed = 16'd27;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; seed = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b1; seed = 16'd9;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("ab_busy", 32'(i16.busy), 0);
    chk("ab_done", 32'(i16.done), 0);
    chk("ab_stp",  32'(i16.steps), 5);
    chk("ab_val",  32'(i16.value), 31);
    chk("ab_pk",   32'(i16.peak), 124);
    repeat (4) @(posedge clk);
    #1;
    chk("ab_hold_stp", 32'(i16.steps), 5);
    chk("ab_hold_val8", 32'(v8), 31);

    // Asynchronous reset between edges in the middle of a trajectory.
    @(posedge clk); #1;
    start = 1'b1; seed = 16'd27;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero16("mrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    go(16'd6);
    chk("r6_val", 32'(i16.value), 1);
    chk("r6_stp", 32'(i16.steps), 8);
    chk("r6_pk",  32'(i16.peak), 16);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
